// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: 2R/2W register file with write bypass, zero register and busy scoreboard
module regfile_mp_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] ra_addr,
   input  logic [ADDR_W-1:0] rb_addr,
   output logic [DATA_W-1:0] ra_data,
   output logic [DATA_W-1:0] rb_data,
   output logic              ra_busy,
   output logic              rb_busy,
   input  logic              wa_en,
   input  logic [ADDR_W-1:0] wa_addr,
   input  logic [DATA_W-1:0] wa_data,
   input  logic              wb_en,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              flush,
   output logic [ADDR_W:0]   busy_cnt
);
   localparam int NUM_REGS = 1 << ADDR_W;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];
   logic [NUM_REGS-1:0] busy_q, busy_d;
   logic [ADDR_W:0]     cnt_q, cnt_d;
   // load writeback beats ALU writeback on a shared address, in storage and in bypass alike
   function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
      if (ZERO_REG && a == '0) return '0;
      if (BYPASS && !reset && wb_en && wb_addr == a) return wb_data;
      if (BYPASS && !reset && wa_en && wa_addr == a) return wa_data;
      return regs_q[a];
   endfunction
   // next register contents, busy bits (flush > issue > writeback clear) and their popcount
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      cnt_d  = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         regs_d[r] = (ZERO_REG && r == 0) ? '0 :
                     (wb_en && wb_addr == ADDR_W'(r)) ? wb_data :
                     (wa_en && wa_addr == ADDR_W'(r)) ? wa_data : regs_q[r];
         busy_d[r] = flush ? 1'b0 :
                     (iss_en && iss_addr == ADDR_W'(r) && !(ZERO_REG && r == 0)) ? 1'b1 :
                     ((wa_en && wa_addr == ADDR_W'(r)) || (wb_en && wb_addr == ADDR_W'(r))) ? 1'b0 :
                     busy_q[r];
         cnt_d = cnt_d + (ADDR_W+1)'(busy_d[r]);
      end
   end
   // state registers; reset overrides writes, issue and flush
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end
   // combinational read ports; busy flags come from stored bits only
   always_comb begin
      ra_data  = rd(ra_addr);
      rb_data  = rd(rb_addr);
      ra_busy  = busy_q[ra_addr];
      rb_busy  = busy_q[rb_addr];
      busy_cnt = cnt_q;
   end
endmodule
